// File: rtl/median_frame_reader_pkg.sv
// Shared types and constants for the median filter result frame buffer and readout.
package median_frame_reader_pkg;

  localparam int IMG_W_DEF = 80;
  localparam int IMG_H_DEF = 60;
  localparam int NUM_PIX   = IMG_W_DEF * IMG_H_DEF;
  localparam int NUM_BYTES = (NUM_PIX + 7) / 8;

  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, PACK, SEND} stateT;

  function automatic logic [31:0] linAddr(input logic [7:0] x, input logic [7:0] y, input int w);
    return 32'(y) * 32'(w) + 32'(x);
  endfunction

endpackage

// File: rtl/median_frame_reader_ram.sv
// 1-bit single-port RAM with registered read, shaped to map onto block RAM.
module median_frame_ram #(
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic          din,
  output logic          q
);

  logic mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    q <= mem[addr];
  end

endmodule

// File: rtl/median_frame_reader.sv
// Captures median filter writes into a 1bpp frame buffer, then streams it out
// as raster-ordered bytes (LSB = earliest pixel) over valid/ready.
module median_frame_reader
  import median_frame_reader_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int AW    = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_x,
  input  logic [7:0] wr_y,
  input  logic       wr_data,
  input  logic       frame_done,
  input  logic       clear_start,
  input  logic       readout_start,
  output logic [7:0] out_byte,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy,
  output logic       frame_ready,
  output logic [7:0] drop_count
);

  localparam int NPIX   = IMG_W * IMG_H;
  localparam int NBYTES = (NPIX + 7) / 8;
  localparam logic [AW-1:0] LASTPIX  = AW'(NPIX - 1);
  localparam logic [AW-1:0] LASTBYTE = AW'(NBYTES - 1);

  stateT         state;
  logic [AW-1:0] clrCnt, pixCnt, byteCnt;
  logic [2:0]    rdPos;
  logic          rdPend;
  logic [7:0]    packReg, packNext;
  logic          inRange, wrOk;
  logic [AW-1:0] wrAddr, ramAddr;
  logic          ramWe, ramDin, ramQ;

  assign inRange = ({24'd0, wr_x} < 32'(IMG_W)) && ({24'd0, wr_y} < 32'(IMG_H));
  assign wrOk    = (state == IDLE) && wr_en && inRange;
  assign wrAddr  = AW'(linAddr(wr_x, wr_y, IMG_W));

  // The filter owns the port only while idle; clear and fetch take it otherwise.
  always_comb begin
    ramAddr = wrAddr;
    ramWe   = wrOk;
    ramDin  = wr_data;
    case (state)
      CLEAR: begin
        ramAddr = clrCnt;
        ramWe   = 1'b1;
        ramDin  = 1'b0;
      end
      FETCH: begin
        ramAddr = pixCnt;
        ramWe   = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    packNext        = packReg;
    packNext[rdPos] = ramQ;
  end

  median_frame_ram #(.AW(AW)) uRam (
    .clk  (clk),
    .addr (ramAddr),
    .we   (ramWe),
    .din  (ramDin),
    .q    (ramQ)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      clrCnt      <= '0;
      pixCnt      <= '0;
      byteCnt     <= '0;
      rdPos       <= '0;
      rdPend      <= 1'b0;
      packReg     <= '0;
      out_byte    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      frame_ready <= 1'b0;
      drop_count  <= '0;
    end else begin
      if (wr_en && !wrOk && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      // Read data lands one cycle after its address was issued.
      if (rdPend) packReg[rdPos] <= ramQ;
      case (state)
        IDLE: begin
          if (frame_done) frame_ready <= 1'b1;
          if (clear_start) begin
            state       <= CLEAR;
            busy        <= 1'b1;
            clrCnt      <= '0;
            drop_count  <= '0;
            frame_ready <= 1'b0;
          end else if (readout_start) begin
            state   <= FETCH;
            busy    <= 1'b1;
            pixCnt  <= '0;
            byteCnt <= '0;
            packReg <= '0;
            rdPend  <= 1'b0;
          end
        end
        CLEAR: begin
          if (clrCnt == LASTPIX) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            clrCnt <= clrCnt + 1'b1;
          end
        end
        FETCH: begin
          rdPend <= 1'b1;
          rdPos  <= pixCnt[2:0];
          if (pixCnt != LASTPIX) pixCnt <= pixCnt + 1'b1;
          if (pixCnt[2:0] == 3'd7 || pixCnt == LASTPIX) state <= PACK;
        end
        PACK: begin
          rdPend    <= 1'b0;
          out_byte  <= packNext;
          out_valid <= 1'b1;
          out_last  <= (byteCnt == LASTBYTE);
          state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= FETCH;
              byteCnt <= byteCnt + 1'b1;
              packReg <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_median_frame_reader.sv
// Randomized bench for median_frame_reader against a pixel-array reference model.
module tb_median_frame_reader;

  localparam int W    = 80;
  localparam int H    = 60;
  localparam int NPIX = W * H;
  localparam int NB   = (NPIX + 7) / 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_x = '0, wr_y = '0;
  logic       wr_data = 1'b0;
  logic       frame_done = 1'b0;
  logic       clear_start = 1'b0;
  logic       readout_start = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_byte;
  logic       out_valid, out_last, busy, frame_ready;
  logic [7:0] drop_count;

  int checks = 0;
  int failures = 0;

  bit         refMem [NPIX];
  int         dropRef = 0;
  logic [7:0] gotBytes [NB];

  always #5 clk = ~clk;

  median_frame_reader dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .frame_done(frame_done), .clear_start(clear_start), .readout_start(readout_start),
    .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .frame_ready(frame_ready), .drop_count(drop_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] expByte(input int b);
    logic [7:0] v = '0;
    for (int i = 0; i < 8; i++)
      if (b * 8 + i < NPIX && refMem[b * 8 + i]) v[i] = 1'b1;
    return v;
  endfunction

  task automatic noteDrop();
    if (dropRef < 255) dropRef++;
  endtask

  task automatic doWrite(input int x, input int y, input bit d);
    wr_en = 1'b1; wr_x = 8'(x); wr_y = 8'(y); wr_data = d;
    step();
    wr_en = 1'b0;
    if (x < W && y < H) refMem[y * W + x] = d;
    else noteDrop();
  endtask

  task automatic randWrites(input int n);
    for (int i = 0; i < n; i++) begin
      int x, y;
      x = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 95));
      y = int'($urandom_range(0, 67));
      doWrite(x, y, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) step();
    end
  endtask

  task automatic doClear(input bit withReadout, input bit injectWrite);
    int n = 0, nValid = 0;
    clear_start = 1'b1; readout_start = withReadout;
    step();
    clear_start = 1'b0; readout_start = 1'b0;
    for (int i = 0; i < NPIX; i++) refMem[i] = 1'b0;
    dropRef = 0;
    while (busy && n < 6000) begin
      if (out_valid) nValid++;
      // Late in the clear, aim a write at an already-cleared pixel.
      if (injectWrite && n == 4790) begin
        wr_en = 1'b1; wr_x = 8'd0; wr_y = 8'd0; wr_data = 1'b1;
        noteDrop();
      end
      step();
      wr_en = 1'b0;
      n++;
    end
    chk("clear_busy_cycles", n, NPIX);
    chk("clear_no_valid", nValid, 0);
    chk("clear_frame_ready", frame_ready, 0);
    chk("clear_drop_count", drop_count, dropRef);
  endtask

  // mode 0: always ready, 1: ready toggles every 3 cycles, 2: random ready + a rejected write
  task automatic doReadout(input int mode, input int stopAt);
    int nb = 0, cyc = 0;
    bit holdV = 0, holdL = 0, rdy;
    logic [7:0] holdB = '0;
    readout_start = 1'b1;
    step();
    readout_start = 1'b0;
    while (nb < NB && cyc < 30000) begin
      if (stopAt >= 0 && nb == stopAt) break;
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc / 3) % 2 == 0) : ($urandom_range(0, 1) == 1);
      out_ready = rdy;
      if (holdV) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_byte", out_byte, holdB);
        chk("hold_last", out_last, holdL);
      end
      if (out_valid) begin
        if (rdy) begin
          chk($sformatf("byte%0d", nb), out_byte, expByte(nb));
          chk($sformatf("last%0d", nb), out_last, (nb == NB - 1));
          gotBytes[nb] = out_byte;
          nb++;
          holdV = 0;
        end else begin
          holdV = 1; holdB = out_byte; holdL = out_last;
        end
      end else holdV = 0;
      if (mode == 2 && cyc == 5) begin
        wr_en = 1'b1; wr_x = 8'd3; wr_y = 8'd3; wr_data = ~refMem[3 * W + 3];
        noteDrop();
      end
      step();
      wr_en = 1'b0;
      cyc++;
    end
    if (stopAt < 0) begin
      chk("handshakes", nb, NB);
      step();
      chk("idle_after_readout", busy, 0);
      chk("drop_after_readout", drop_count, dropRef);
    end
  endtask

  initial begin
    int n;
    repeat (3) step();
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_byte", out_byte, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_ready", frame_ready, 0);
    chk("rst_drop", drop_count, 0);
    reset = 1'b0;
    step();

    doClear(1'b0, 1'b1);
    doReadout(0, -1);

    doWrite(255, 10, 1'b1);
    doWrite(80, 0, 1'b1);
    chk("drop_three", drop_count, 3);

    doWrite(0, 0, 1'b1);
    doWrite(7, 0, 1'b1);
    doWrite(79, 59, 1'b1);
    doReadout(0, -1);
    chk("const_byte0", gotBytes[0], 8'h81);
    chk("const_byte599", gotBytes[NB - 1], 8'h80);
    chk("const_byte1", gotBytes[1], 8'h00);
    doReadout(1, -1);

    randWrites(150);
    frame_done = 1'b1; step(); frame_done = 1'b0;
    chk("frame_ready_set", frame_ready, 1);
    chk("drop_random", drop_count, dropRef);
    doReadout(2, -1);

    doClear(1'b1, 1'b0);
    frame_done = 1'b1; step(); frame_done = 1'b0;
    chk("frame_ready_again", frame_ready, 1);

    randWrites(120);
    doReadout(0, 100);
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin step(); n++; end
    chk("byte100_presented", out_valid, 1);
    reset = 1'b1;
    step();
    chk("midrst_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_last", out_last, 0);
    reset = 1'b0;
    dropRef = 0;
    step();
    chk("midrst_drop", drop_count, 0);
    doReadout(0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/median_frame_reader.md
Name: median_frame_reader

Overview:
- Receiving end of the median filter's result-write interface: the x/y address, data and write strobe the filter emits when a median pixel is 1.
- Holds a 1-bit-per-pixel frame buffer of the filtered image and clears it before each frame. Clearing is required because the filter only writes 1s.
- After the frame completes, reads the buffer in raster order, packs 8 pixels per byte and streams the bytes out on a valid/ready byte interface toward the host link.

Parameters:
- IMG_W, 80, filtered image width in pixels.
- IMG_H, 60, filtered image height in pixels.
- AW, 13, linear address width; must satisfy 2^AW >= IMG_W*IMG_H.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- wr_en  in  1  median write strobe from the filter
- wr_x  in  8  pixel column
- wr_y  in  8  pixel row
- wr_data  in  1  pixel value
- frame_done  in  1  filter full-image-done level/pulse
- clear_start  in  1  request buffer clear (pulse)
- readout_start  in  1  request frame readout (pulse)
- out_byte  out  8  packed pixels, LSB = earliest pixel
- out_valid  out  1  out_byte valid
- out_ready  in  1  downstream accepts byte
- out_last  out  1  final byte of frame, qualified by out_valid
- busy  out  1  high in CLEAR/FETCH/PACK/SEND
- frame_ready  out  1  frame_done seen since last clear
- drop_count  out  8  saturating count of rejected writes since last clear

Behaviour:
- Reset: all outputs 0, FSM to IDLE. Buffer contents are undefined after reset; a clear is required.
- Linear address = wr_y*IMG_W + wr_x.
- Memory: single-port synchronous RAM with 1-cycle read latency. The FSM muxes the port.
- Write acceptance, in IDLE only:
  - wr_en=1 with wr_x<IMG_W and wr_y<IMG_H: writes wr_data.
  - Any other wr_en=1 cycle increments drop_count, saturating at 255. This covers out-of-range addresses (e.g. 255 from the filter's x-1 at column 0) and writes in any non-IDLE state.
- frame_ready: set on frame_done=1 in IDLE; cleared on entry to CLEAR.
- IDLE:
  - clear_start goes to CLEAR.
  - Otherwise readout_start goes to FETCH.
  - If both are asserted in the same cycle, clear wins and readout_start is dropped.
  - Start pulses outside IDLE are ignored.
- CLEAR:
  - Writes 0 to addresses 0..IMG_W*IMG_H-1, one per cycle; takes IMG_W*IMG_H cycles (4800 by default).
  - Zeroes drop_count on entry.
  - Returns to IDLE.
- FETCH/PACK:
  - Issues reads in raster order (y outer, x inner).
  - Read data shifts into bit position (pixel_index mod 8).
  - After 8 pixels, or after the final pixel, goes to SEND.
  - If IMG_W*IMG_H is not a multiple of 8, unused upper bits of the final byte are 0.
  - Back-to-back reads are pipelined, so a byte takes 9 cycles from its first read address.
- SEND:
  - out_valid=1.
  - out_byte and out_last stay stable until out_ready=1.
  - On the handshake: if the byte was the last one, go to IDLE; otherwise go to FETCH for the next byte.
  - out_last=1 only on byte ceil(IMG_W*IMG_H/8)-1 (byte 599 by default).
- Readout does not modify the buffer; repeated readouts return identical data.
- Reset mid-CLEAR or mid-readout: immediate IDLE, out_valid drops the same cycle, no partial out_last.
- Counters are sized from AW. Pixel and byte counters never wrap past the frame end.

Decomposition:
- Shared package: state enum (IDLE, CLEAR, FETCH, PACK, SEND), IMG_W/IMG_H defaults, the derived NUM_PIX and NUM_BYTES constants, and the linear-address function.
- One sub-module, median_frame_ram: a 1-bit synchronous single-port RAM of depth 2^AW with registered output, so it can map to device block RAM.

Test Plan:
- Reset then clear: assert clear_start.
  - busy is high for exactly 4800 cycles.
  - A following readout returns 600 bytes of 0x00, with out_last only on byte 599.
- Writes at (0,0), (7,0) and (79,59) with wr_data=1, then readout with out_ready=1:
  - byte0 = 0x81 (bits 0 and 7 set);
  - byte599 = 0x80 (bit 7 set);
  - all other bytes 0x00.
- Backpressure: toggle out_ready every 3 cycles during readout.
  - out_byte and out_last are held stable while out_ready=0.
  - Exactly 600 handshakes occur, and the data is identical to the out_ready=1 run.
- Rejected writes, counted in drop_count:
  - wr_en at (255,10) and at (80,0) in IDLE;
  - one wr_en during CLEAR.
  - Result: drop_count=3 and none of these writes corrupt the buffer.
- Simultaneous clear_start and readout_start in IDLE:
  - CLEAR runs and no out_valid appears.
  - frame_ready goes to 0, then returns to 1 after a frame_done pulse.
- Reset asserted at byte 100 of a readout:
  - the next cycle shows out_valid=0, busy=0, out_last=0.
  - A new readout_start restarts from byte 0 with unchanged data.
